// File: rtl/mul_dispatcher.sv
// mul_dispatcher: operand queue and sequencer in front of the 64x64 radix-4
// Booth multiplier. Operand pairs are buffered in an input FIFO, issued one
// at a time with an op_start pulse, and each product is captured into an
// output FIFO before the multiplier is cleared with an op_clear pulse.
//
// Optional feature: define MUL_TIMEOUT_EN to enable a watchdog on the WAIT
// state. A job that does not see op_done within TIMEOUT_CYC cycles is dropped
// and err_timeout is set sticky until reset.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   in_valid/in_ready               operand push handshake (in_ready = not full)
//   in_multiplier/in_multiplicand   64-bit operand pair
//   out_valid/out_ready             result pop handshake (out_valid = not empty)
//   out_result                      128-bit head of the output FIFO
//   mul_multiplier/mul_multiplicand operands held for the job in flight
//   mul_op_start/mul_op_clear       one-cycle pulses to the multiplier
//   mul_op_done/mul_result          level-held completion and product
//   busy                            FSM active or input FIFO not empty
//   pending                         jobs accepted but not yet written out
//   err_timeout                     sticky watchdog flag
module mul_dispatcher #(
  parameter int unsigned IN_DEPTH    = 4,
  parameter int unsigned OUT_DEPTH   = 2,
  parameter int unsigned TIMEOUT_CYC = 80
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_multiplier,
  input  logic [63:0]  in_multiplicand,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_result,
  output logic [63:0]  mul_multiplier,
  output logic [63:0]  mul_multiplicand,
  output logic         mul_op_start,
  output logic         mul_op_clear,
  input  logic         mul_op_done,
  input  logic [127:0] mul_result,
  output logic         busy,
  output logic [7:0]   pending,
  output logic         err_timeout
);

  localparam int unsigned IN_AW  = $clog2(IN_DEPTH);
  localparam int unsigned IN_PW  = IN_AW + 1;
  localparam int unsigned OUT_AW = $clog2(OUT_DEPTH);
  localparam int unsigned OUT_PW = OUT_AW + 1;

  // Reject configurations the pointer arithmetic cannot support
  if (IN_DEPTH < 2 || (IN_DEPTH & (IN_DEPTH - 1)) != 0) begin : g_bad_in_depth
    $error("IN_DEPTH must be a power of 2 and >= 2");
  end
  if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_out_depth
    $error("OUT_DEPTH must be a power of 2 and >= 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t state;

  // Input FIFO storage and pointers
  logic [63:0]      in_mlt_mem [IN_DEPTH];
  logic [63:0]      in_mcd_mem [IN_DEPTH];
  logic [IN_PW-1:0] in_wr_ptr;
  logic [IN_PW-1:0] in_rd_ptr;
  logic [IN_PW-1:0] in_cnt;
  logic [IN_PW-1:0] in_cnt_nxt;
  logic             in_push;
  logic             in_pop;

  // Output FIFO storage and pointers
  logic [127:0]      out_mem [OUT_DEPTH];
  logic [OUT_PW-1:0] out_wr_ptr;
  logic [OUT_PW-1:0] out_rd_ptr;
  logic [OUT_PW-1:0] out_cnt;
  logic [OUT_PW-1:0] out_cnt_nxt;
  logic [OUT_AW-1:0] out_rd_nidx;
  logic              out_full;
  logic              out_push;
  logic              out_pop;

  logic              timeout_hit;

  // Handshake and occupancy terms derived from registered state
  always_comb begin
    in_cnt      = in_wr_ptr - in_rd_ptr;
    in_push     = in_valid & in_ready;
    in_pop      = (state == S_IDLE) && (in_cnt != '0);
    in_cnt_nxt  = in_cnt + IN_PW'(in_push) - IN_PW'(in_pop);

    out_cnt     = out_wr_ptr - out_rd_ptr;
    out_full    = (out_cnt == OUT_PW'(OUT_DEPTH));
    out_pop     = out_valid & out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    out_push    = (state == S_WAIT) && mul_op_done && (!out_full || out_pop) && !timeout_hit;
    out_cnt_nxt = out_cnt + OUT_PW'(out_push) - OUT_PW'(out_pop);
    out_rd_nidx = out_rd_ptr[OUT_AW-1:0] + OUT_AW'(1);
  end

`ifdef MUL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] wait_cnt;

  // Timeout wins over an op_done arriving on the same cycle
  assign timeout_hit = (state == S_WAIT) && (wait_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Watchdog counter and sticky error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + TO_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // FIFO payload storage; no reset needed, reads are guarded by occupancy
  always_ff @(posedge clk) begin
    if (in_push) begin
      in_mlt_mem[in_wr_ptr[IN_AW-1:0]] <= in_multiplier;
      in_mcd_mem[in_wr_ptr[IN_AW-1:0]] <= in_multiplicand;
    end
    if (out_push) begin
      out_mem[out_wr_ptr[OUT_AW-1:0]] <= mul_result;
    end
  end

  // Sequencer FSM, FIFO pointers and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      in_wr_ptr        <= '0;
      in_rd_ptr        <= '0;
      out_wr_ptr       <= '0;
      out_rd_ptr       <= '0;
      in_ready         <= 1'b1;
      out_valid        <= 1'b0;
      out_result       <= '0;
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
      mul_op_start     <= 1'b0;
      mul_op_clear     <= 1'b0;
      busy             <= 1'b0;
      pending          <= '0;
    end else begin
      mul_op_start <= 1'b0;
      mul_op_clear <= 1'b0;
      busy         <= 1'b1;

      if (in_push) in_wr_ptr  <= in_wr_ptr + IN_PW'(1);
      if (in_pop)  in_rd_ptr  <= in_rd_ptr + IN_PW'(1);
      if (out_push) out_wr_ptr <= out_wr_ptr + OUT_PW'(1);
      if (out_pop)  out_rd_ptr <= out_rd_ptr + OUT_PW'(1);

      in_ready  <= (in_cnt_nxt != IN_PW'(IN_DEPTH));
      out_valid <= (out_cnt_nxt != '0);
      pending   <= pending + 8'(in_push) - 8'(out_push | timeout_hit);

      // Keep out_result equal to the head entry the next cycle will present
      if (out_push && (out_cnt == '0 || (out_cnt == OUT_PW'(1) && out_pop))) begin
        out_result <= mul_result;
      end else if (out_pop && out_cnt > OUT_PW'(1)) begin
        out_result <= out_mem[out_rd_nidx];
      end else if (out_pop) begin
        out_result <= '0;
      end

      case (state)
        S_IDLE: begin
          if (in_pop) begin
            mul_multiplier   <= in_mlt_mem[in_rd_ptr[IN_AW-1:0]];
            mul_multiplicand <= in_mcd_mem[in_rd_ptr[IN_AW-1:0]];
            mul_op_start     <= 1'b1;
            state            <= S_ISSUE;
          end else begin
            busy <= (in_cnt_nxt != '0);
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A full output FIFO holds us here; the multiplier keeps its result
          if (out_push || timeout_hit) begin
            mul_op_clear <= 1'b1;
            state        <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          state <= S_IDLE;
          busy  <= (in_cnt_nxt != '0);
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_dispatcher.sv
// tb_mul_dispatcher: directed bench for mul_dispatcher with a behavioural
// signed 64x64 multiplier that raises op_done 64 cycles after op_start.
module tb_mul_dispatcher;

  localparam int unsigned TIMEOUT_CYC = 80;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_multiplier;
  logic [63:0]  in_multiplicand;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_result;
  logic [63:0]  mul_multiplier;
  logic [63:0]  mul_multiplicand;
  logic         mul_op_start;
  logic         mul_op_clear;
  logic         mul_op_done;
  logic [127:0] mul_result;
  logic         busy;
  logic [7:0]   pending;
  logic         err_timeout;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int starts_cnt = 0;
  int clears_cnt = 0;
  int both_cnt   = 0;

  mul_dispatcher #(.IN_DEPTH(4), .OUT_DEPTH(2), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_multiplier    (in_multiplier),
    .in_multiplicand  (in_multiplicand),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_op_start     (mul_op_start),
    .mul_op_clear     (mul_op_clear),
    .mul_op_done      (mul_op_done),
    .mul_result       (mul_result),
    .busy             (busy),
    .pending          (pending),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: signed product, done held until op_clear
  logic        m_run;
  logic [6:0]  m_cnt;
  logic        m_no_done = 1'b0;
  logic signed [127:0] ext_a, ext_b, prod;

  always_comb begin
    ext_a = {{64{mul_multiplier[63]}}, mul_multiplier};
    ext_b = {{64{mul_multiplicand[63]}}, mul_multiplicand};
    prod  = ext_a * ext_b;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run       <= 1'b0;
      m_cnt       <= '0;
      mul_op_done <= 1'b0;
      mul_result  <= '0;
    end else if (mul_op_clear) begin
      m_run       <= 1'b0;
      mul_op_done <= 1'b0;
    end else if (mul_op_start) begin
      m_run      <= 1'b1;
      m_cnt      <= 7'd64;
      mul_result <= prod;
    end else if (m_run) begin
      m_cnt <= m_cnt - 7'd1;
      if (m_cnt == 7'd1) begin
        m_run       <= 1'b0;
        mul_op_done <= !m_no_done;
      end
    end
  end

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (mul_op_start) starts_cnt++;
    if (mul_op_clear) clears_cnt++;
    if (mul_op_start && mul_op_clear) both_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Push one operand pair, waiting (bounded) for space
  task automatic push(input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    in_valid        = 1'b1;
    in_multiplier   = a;
    in_multiplicand = b;
    while (!in_ready && n < 400) begin
      tick();
      n++;
    end
    check("push_space", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a result at the head, check it, then pop it
  task automatic take(input string tag, input logic [127:0] exp);
    int n = 0;
    while (!out_valid && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 128'(out_valid), 128'(1));
    check(tag, out_result, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int s0, c0;
    int t0, t1;
    logic [127:0] exp5 [5];

    reset_n         = 1'b0;
    in_valid        = 1'b0;
    in_multiplier   = '0;
    in_multiplicand = '0;
    out_ready       = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_in_ready",  128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_result", out_result, 128'(0));
    check("rst_mul_ops", {mul_multiplier, mul_multiplicand}, 128'(0));
    check("rst_start_clear", 128'({mul_op_start, mul_op_clear}), 128'(0));
    check("rst_busy_pend", 128'({busy, pending}), 128'(0));
    check("rst_err", 128'(err_timeout), 128'(0));
    reset_n = 1'b1;
    tick();

    // Single job 3 x 5 with latency and pulse-width checks
    s0 = starts_cnt;
    c0 = clears_cnt;
    push(64'd3, 64'd5);
    check("single_pending", 128'(pending), 128'(1));
    check("single_busy", 128'(busy), 128'(1));
    lat = 0;
    while (!out_valid && lat < 300) begin
      tick();
      lat++;
    end
    check("single_latency", 128'(lat), 128'(67));
    check("single_result", out_result, 128'h0F);
    check("single_clear_now", 128'(mul_op_clear), 128'(1));
    check("single_pend_after", 128'(pending), 128'(0));
    tick(); tick(); tick();
    check("single_start_cycles", 128'(starts_cnt - s0), 128'(1));
    check("single_clear_cycles", 128'(clears_cnt - c0), 128'(1));
    check("single_ops_held", {mul_multiplier, mul_multiplicand}, {64'd3, 64'd5});
    check("single_idle_busy", 128'(busy), 128'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_popped", 128'(out_valid), 128'(0));

    // Signed products
    push(64'hFFFF_FFFF_FFFF_FFFF, 64'd7);
    take("neg1x7", 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF9);
    push(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    take("minxmin", 128'h4000_0000_0000_0000_0000_0000_0000_0000);

    // Five jobs back-to-back: queue fills, results in order, interval 68
    exp5[0] = 128'd6;
    exp5[1] = 128'd200;
    exp5[2] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA;
    exp5[3] = 128'h12340;
    exp5[4] = 128'd0;
    push(64'd2, 64'd3);
    push(64'd10, 64'd20);
    push(64'hFFFF_FFFF_FFFF_FFFE, 64'd3);
    push(64'h1234, 64'h10);
    push(64'd0, 64'd99);
    check("five_pending_peak", 128'(pending), 128'(5));
    check("five_in_full", 128'(in_ready), 128'(0));
    t0 = 0;
    t1 = 0;
    for (int k = 0; k < 5; k++) begin
      int n = 0;
      while (!out_valid && n < 400) begin
        tick();
        n++;
      end
      if (k == 0) t0 = cyc;
      if (k == 1) t1 = cyc;
      check($sformatf("five_res%0d", k), out_result, exp5[k]);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("five_interval", 128'(t1 - t0), 128'(68));
    check("five_pend_end", 128'(pending), 128'(0));
    check("five_in_ready", 128'(in_ready), 128'(1));

    // Output backpressure: third job stalls in WAIT with op_done held
    push(64'd11, 64'd13);
    push(64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB);
    push(64'h1_0000_0000, 64'h1_0000_0000);
    for (int i = 0; i < 260; i++) tick();
    check("bp_done_held", 128'(mul_op_done), 128'(1));
    check("bp_pending", 128'(pending), 128'(1));
    check("bp_no_clear", 128'(mul_op_clear), 128'(0));
    check("bp_head", out_result, 128'd143);
    take("bp_res0", 128'd143);
    take("bp_res1", 128'd25);
    take("bp_res2", 128'h1_0000_0000_0000_0000);
    check("bp_pend_end", 128'(pending), 128'(0));

    // Reset mid-job abandons it; next job is correct
    push(64'd21, 64'd2);
    for (int i = 0; i < 30; i++) tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_start_clear", 128'({mul_op_start, mul_op_clear}), 128'(0));
    check("mid_rst_status", 128'({busy, pending, out_valid, in_ready}), 128'({1'b0, 8'd0, 1'b0, 1'b1}));
    check("mid_rst_ops", {mul_multiplier, mul_multiplicand}, 128'(0));
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    push(64'd100, 64'hFFFF_FFFF_FFFF_FF9C);
    take("after_rst", 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_D8F0);

`ifdef MUL_TIMEOUT_EN
    // Watchdog: job dropped, error sticky, next job normal
    m_no_done = 1'b1;
    push(64'd9, 64'd9);
    lat = 0;
    while (!err_timeout && lat < 300) begin
      tick();
      lat++;
    end
    check("to_latency", 128'(lat), 128'(TIMEOUT_CYC + 2));
    check("to_clear", 128'(mul_op_clear), 128'(1));
    check("to_pending", 128'(pending), 128'(0));
    check("to_no_out", 128'(out_valid), 128'(0));
    m_no_done = 1'b0;
    tick();
    push(64'd4, 64'd5);
    take("to_next", 128'd20);
    check("to_sticky", 128'(err_timeout), 128'(1));
`else
    check("err_tied", 128'(err_timeout), 128'(0));
`endif

    check("never_both_pulses", 128'(both_cnt), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
